// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - APB bus interface used by the imem fetch port
interface apb_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end with prefetch queue and JAL prediction
module apb_controller_sbm #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [31:0]       rdata_o,
    apb_if.master             apb
);
    typedef enum logic [1:0] {C_IDLE, C_SETUP, C_ACCESS} cstate_t;

    cstate_t           state_q;
    logic              psel_q;
    logic              penable_q;
    logic [ADDR_W-1:0] paddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= C_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (start_i) begin
                        psel_q  <= 1'b1;
                        paddr_q <= addr_i;
                        state_q <= C_SETUP;
                    end
                end
                C_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= C_ACCESS;
                end
                C_ACCESS: begin
                    if (apb.pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= C_IDLE;
                    end
                end
                default: state_q <= C_IDLE;
            endcase
        end
    end

    // Completion is reported in the handshake cycle itself so the caller can push on that edge.
    assign ready_o      = (state_q == C_IDLE);
    assign resp_valid_o = (state_q == C_ACCESS) && apb.pready && !apb.pslverr;
    assign resp_err_o   = (state_q == C_ACCESS) && apb.pready && apb.pslverr;
    assign rdata_o      = apb.prdata;

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = 1'b0;
    assign apb.pwdata  = '0;
endmodule

module fetch_queue_unit #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] INIT_PC     = '0,
    parameter int                DEPTH       = 4,
    parameter bit                JAL_PREDICT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    apb_if.master                    imem_apb,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [31:0]              inst_o,
    output logic                     pred_taken_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o,
    output logic [ADDR_W-1:0]        err_pc_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD, ERROR} state_t;

    state_t            state_q;
    logic              start_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              err_q;
    logic [ADDR_W-1:0] err_pc_q;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic              pred_mem [DEPTH];
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;
    logic [CW-1:0]     count_q;
    logic [ADDR_W-1:0] last_pc_q;
    logic [31:0]       last_inst_q;
    logic              last_pred_q;

    logic              ctrl_ready;
    logic              ctrl_resp;
    logic              ctrl_err;
    logic [31:0]       ctrl_rdata;

    apb_controller_sbm #(.ADDR_W(ADDR_W)) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_q),
        .addr_i       (req_pc_q),
        .ready_o      (ctrl_ready),
        .resp_valid_o (ctrl_resp),
        .resp_err_o   (ctrl_err),
        .rdata_o      (ctrl_rdata),
        .apb          (imem_apb)
    );

    logic              pending;
    logic              issue;
    logic              push;
    logic              pop;
    logic              is_jal;
    logic [20:0]       jal_imm;
    logic [ADDR_W-1:0] jal_target;

    // An outstanding read owns a queue slot, so a response can always be pushed.
    assign pending    = (state_q == BUSY);
    assign issue      = (state_q == IDLE) && ctrl_ready && !redirect_i
                        && ((count_q + CW'(pending)) < CW'(DEPTH));
    assign push       = (state_q == BUSY) && ctrl_resp && !redirect_i;
    assign pop        = (count_q != '0) && ready_i && !redirect_i;
    assign is_jal     = JAL_PREDICT && (ctrl_rdata[6:0] == 7'b1101111);
    assign jal_imm    = {ctrl_rdata[31], ctrl_rdata[19:12], ctrl_rdata[20], ctrl_rdata[30:21], 1'b0};
    assign jal_target = req_pc_q + {{(ADDR_W-21){jal_imm[20]}}, jal_imm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            req_pc_q   <= '0;
            fetch_pc_q <= INIT_PC;
            err_q      <= 1'b0;
            err_pc_q   <= '0;
        end else begin
            start_q <= 1'b0;
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc_i & ~ADDR_W'(3);
                err_q      <= 1'b0;
                state_q    <= ((state_q == BUSY || state_q == DISCARD) && !ctrl_resp && !ctrl_err)
                              ? DISCARD : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (issue) begin
                            start_q    <= 1'b1;
                            req_pc_q   <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                            state_q    <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (ctrl_resp) begin
                            if (is_jal) fetch_pc_q <= jal_target;
                            state_q <= IDLE;
                        end else if (ctrl_err) begin
                            err_q    <= 1'b1;
                            err_pc_q <= req_pc_q;
                            state_q  <= ERROR;
                        end
                    end
                    DISCARD: begin
                        if (ctrl_resp || ctrl_err) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            last_pc_q   <= '0;
            last_inst_q <= '0;
            last_pred_q <= 1'b0;
        end else if (redirect_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop) begin
                rd_q        <= rd_q + PW'(1);
                last_pc_q   <= pc_mem[rd_q];
                last_inst_q <= inst_mem[rd_q];
                last_pred_q <= pred_mem[rd_q];
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= req_pc_q;
            inst_mem[wr_q] <= ctrl_rdata;
            pred_mem[wr_q] <= is_jal;
        end
    end

    // Empty queue keeps showing the most recently popped entry.
    assign valid_o      = (count_q != '0);
    assign pc_o         = valid_o ? pc_mem[rd_q]   : last_pc_q;
    assign inst_o       = valid_o ? inst_mem[rd_q] : last_inst_q;
    assign pred_taken_o = valid_o ? pred_mem[rd_q] : last_pred_q;
    assign count_o      = count_q;
    assign err_o        = err_q;
    assign err_pc_o     = err_pc_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        pred_taken_o;
    logic [2:0]  count_o;
    logic        err_o;
    logic [31:0] err_pc_o;

    apb_if #(.ADDR_W(32)) bus ();

    fetch_queue_unit #(
        .ADDR_W      (32),
        .INIT_PC     (32'h0),
        .DEPTH       (4),
        .JAL_PREDICT (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_apb      (bus),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .pred_taken_o  (pred_taken_o),
        .count_o       (count_o),
        .err_o         (err_o),
        .err_pc_o      (err_pc_o)
    );

    always #5 clk = ~clk;

    // imem slave: word derived from the address, optional JAL at 0x8, wait states, error address.
    int          wait_states = 0;
    int          wait_cnt    = 0;
    logic        err_en      = 1'b0;
    logic [31:0] err_addr    = 32'h0;
    logic        jal_en      = 1'b0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a, input logic j);
        if (j && a == 32'h8) return 32'h1000_006F;
        return {a[24:0], 7'h13};
    endfunction

    assign bus.pready  = bus.psel && bus.penable && (wait_cnt >= wait_states);
    assign bus.pslverr = bus.pready && err_en && (bus.paddr == err_addr);
    assign bus.prdata  = rdata_of(bus.paddr, jal_en);

    always @(posedge clk) begin
        if (bus.psel && bus.penable && !bus.pready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    logic [31:0] log_q[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];
    logic        dlv_pred[$];
    int          ncyc, first_hs, first_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            log_q.delete();
            dlv_pc.delete();
            dlv_inst.delete();
            dlv_pred.delete();
            ncyc        <= 0;
            first_hs    <= -1;
            first_valid <= -1;
        end else begin
            ncyc <= ncyc + 1;
            if (bus.psel && !bus.penable) log_q.push_back(bus.paddr);
            if (bus.psel && bus.penable && bus.pready && first_hs < 0) first_hs <= ncyc;
            if (valid_o && first_valid < 0) first_valid <= ncyc;
            if (valid_o && ready_i) begin
                dlv_pc.push_back(pc_o);
                dlv_inst.push_back(inst_o);
                dlv_pred.push_back(pred_taken_o);
            end
        end
    end

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        ready_i       = 1'b1;

        // Reset values, then streaming with decode always ready.
        do_reset();
        check("rst_valid", valid_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_pred", pred_taken_o, 0);
        check("rst_count", count_o, 0);
        check("rst_err", err_o, 0);
        check("rst_err_pc", err_pc_o, 0);
        n = 0;
        while (dlv_pc.size() < 4 && n < 100) begin cyc(1); n++; end
        check("stream_timeout", dlv_pc.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_pc%0d", i), dlv_pc[i], 32'(i * 4));
            check($sformatf("stream_inst%0d", i), dlv_inst[i], rdata_of(32'(i * 4), 1'b0));
            check($sformatf("stream_pred%0d", i), dlv_pred[i], 0);
        end
        check("first_valid_latency", 64'(first_valid - first_hs), 1);

        // Full-queue stall, then drain at one pop per cycle.
        ready_i = 1'b0;
        do_reset();
        cyc(40);
        check("full_count", count_o, 4);
        check("full_no_5th_psel", log_q.size(), 4);
        check("full_head_pc", pc_o, 0);
        ready_i = 1'b1;
        cyc(1); check("drain1_count", count_o, 3); check("drain1_pc", pc_o, 32'h4);
        cyc(1); check("drain2_count", count_o, 2); check("drain2_pc", pc_o, 32'h8);
        cyc(1); check("drain3_count", count_o, 1); check("drain3_pc", pc_o, 32'hC);
        cyc(1); check("drain4_count", count_o, 0); check("drain4_valid", valid_o, 0);
        check("empty_holds_pc", pc_o, 32'hC);
        n = 0;
        while (log_q.size() < 5 && n < 50) begin cyc(1); n++; end
        check("resume_addr", log_q[4], 32'h10);

        // JAL at 0x8 with +0x100.
        ready_i = 1'b0;
        jal_en  = 1'b1;
        do_reset();
        n = 0;
        while (count_o != 4 && n < 100) begin cyc(1); n++; end
        check("jal_fill_timeout", count_o, 4);
        check("jal_req_count", log_q.size(), 4);
        check("jal_target_fetch", log_q[3], 32'h108);
        check("jal_head0_pred", pred_taken_o, 0);
        ready_i = 1'b1;
        cyc(1); check("jal_head1_pc", pc_o, 32'h4);
        cyc(1); check("jal_head2_pc", pc_o, 32'h8);
        check("jal_head2_pred", pred_taken_o, 1);
        check("jal_head2_inst", inst_o, 32'h1000_006F);
        cyc(1); check("jal_head3_pc", pc_o, 32'h108);
        check("jal_head3_pred", pred_taken_o, 0);
        jal_en = 1'b0;

        // Redirect while a wait-stated read is in flight.
        ready_i     = 1'b0;
        wait_states = 3;
        do_reset();
        n = 0;
        while (!(log_q.size() == 2 && bus.psel && bus.penable) && n < 100) begin cyc(1); n++; end
        check("disc_inflight_timeout", log_q.size() == 2 && bus.psel && bus.penable, 1);
        check("disc_pre_count", count_o, 1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        cyc(1);
        redirect_i = 1'b0;
        check("disc_count", count_o, 0);
        check("disc_valid", valid_o, 0);
        n = 0;
        while (count_o != 1 && n < 100) begin cyc(1); n++; end
        check("disc_next_fetch", log_q[2], 32'h200);
        check("disc_head_pc", pc_o, 32'h200);
        check("disc_head_inst", inst_o, rdata_of(32'h200, 1'b0));
        wait_states = 0;

        // PSLVERR at 0x40, then recovery by redirect to 0x80.
        err_en        = 1'b1;
        err_addr      = 32'h40;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        do_reset();
        cyc(1);
        redirect_i = 1'b0;
        n = 0;
        while (!err_o && n < 50) begin cyc(1); n++; end
        check("err_flag", err_o, 1);
        check("err_pc", err_pc_o, 32'h40);
        cyc(10);
        check("err_no_more_psel", log_q.size(), 1);
        check("err_count", count_o, 0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        cyc(1);
        redirect_i = 1'b0;
        check("err_cleared", err_o, 0);
        n = 0;
        while (log_q.size() < 2 && n < 50) begin cyc(1); n++; end
        check("err_recover_fetch", log_q[1], 32'h80);
        err_en = 1'b0;

        // Redirect coinciding with push+pop when count+pending is at DEPTH; PC wraps.
        ready_i = 1'b0;
        do_reset();
        n = 0;
        while (!(log_q.size() == 4 && bus.psel && bus.penable) && n < 100) begin cyc(1); n++; end
        check("wrap_resp_timeout", log_q.size() == 4 && bus.psel && bus.penable, 1);
        check("wrap_pre_count", count_o, 3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        ready_i       = 1'b1;
        cyc(1);
        redirect_i = 1'b0;
        check("wrap_count", count_o, 0);
        check("wrap_valid", valid_o, 0);
        check("wrap_hold_pc", pc_o, 0);
        n = 0;
        while (log_q.size() < 6 && n < 100) begin cyc(1); n++; end
        check("wrap_req_top", log_q[4], 32'hFFFF_FFFC);
        check("wrap_req_zero", log_q[5], 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
